sdram_req_arbiter: RTL and testbench

Parametrised N-channel command arbiter in front of the 16-bit SDRAM controller's `sys_CMD`/`sys_ADDR`/`sys_cmd_ack` port. It replaces the fixed video/cache-write/cache-read priority chain in the top level with configurable urgent and round-robin channels. It tracks one outstanding command through its data phase and demultiplexes the read and write data-valid strobes back to the owning channel.

---
 rtl/sdram_req_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_sdram_req_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_req_arbiter.sv
// Command arbiter in front of the SDRAM controller: urgent channels win by index,
// the rest share round-robin; one command is tracked through its data phase.
module sdram_req_arbiter #(
    parameter int NCH = 4,
    parameter int AW = 23,
    parameter logic [NCH-1:0] URGENT = {{(NCH-1){1'b0}}, 1'b1},
    parameter int BEATS_SHORT = 16,
    parameter int BEATS_LONG = 128,
    parameter int TIMEOUT = 1023,
    localparam int CW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    req,
    input  logic [2*NCH-1:0]  req_cmd,
    input  logic [AW*NCH-1:0] req_addr,
    output logic [NCH-1:0]    gnt,
    output logic [1:0]        sys_CMD,
    output logic [AW-1:0]     sys_ADDR,
    input  logic [1:0]        sys_cmd_ack,
    input  logic              sys_rd_data_valid,
    input  logic              sys_wr_data_valid,
    output logic [NCH-1:0]    rd_valid,
    output logic [NCH-1:0]    wr_valid,
    output logic [CW-1:0]     owner,
    output logic              busy,
    output logic              err
);

    localparam int BW = $clog2(BEATS_LONG + 1);
    localparam int WW = $clog2(TIMEOUT + 1);
    localparam logic [NCH-1:0] ONE = {{(NCH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE = 2'b00, ISSUE = 2'b01, DATA = 2'b10} state_t;

    state_t          state_q;
    logic [CW-1:0]   ch_q;
    logic [CW-1:0]   rr_q;
    logic [CW-1:0]   owner_q;
    logic [1:0]      cmd_q;
    logic [1:0]      sys_cmd_q;
    logic [AW-1:0]   sys_addr_q;
    logic [NCH-1:0]  gnt_q;
    logic [BW-1:0]   beats_q;
    logic [WW-1:0]   wd_q;
    logic            busy_q;
    logic            err_q;

    logic [NCH-1:0]  elig_s;
    logic [CW-1:0]   urg_sel_s;
    logic [CW-1:0]   rr_sel_s;
    logic [CW-1:0]   sel_s;
    logic            urg_any_s;
    logic            rr_any_s;
    logic            any_s;
    logic [1:0]      sel_cmd_s;
    logic [AW-1:0]   sel_addr_s;

    logic            is_rd_s;
    logic            in_data_s;
    logic            rd_hit_s;
    logic            wr_hit_s;
    logic            beat_s;
    logic            last_beat_s;
    logic            bad_strobe_s;
    logic            wd_exp_s;
    logic [NCH-1:0]  owner_oh_s;

    // Eligibility, lowest urgent index first, else first non-urgent after rr_q
    always_comb begin
        logic [CW-1:0] idx;
        elig_s     = {NCH{1'b0}};
        urg_sel_s  = {CW{1'b0}};
        urg_any_s  = 1'b0;
        rr_sel_s   = {CW{1'b0}};
        rr_any_s   = 1'b0;
        idx        = {CW{1'b0}};
        sel_cmd_s  = 2'b00;
        sel_addr_s = {AW{1'b0}};
        for (int i = 0; i < NCH; i++) begin
            elig_s[i] = req[i] & (req_cmd[2*i +: 2] != 2'b00);
        end
        for (int i = NCH - 1; i >= 0; i--) begin
            urg_sel_s = (elig_s[i] & URGENT[i]) ? CW'(i) : urg_sel_s;
            urg_any_s = urg_any_s | (elig_s[i] & URGENT[i]);
        end
        // Descending walk so the closest channel after rr_q is the last to overwrite
        for (int k = NCH; k >= 1; k--) begin
            idx      = CW'((int'(rr_q) + k) % NCH);
            rr_sel_s = (elig_s[idx] & ~URGENT[idx]) ? idx : rr_sel_s;
            rr_any_s = rr_any_s | (elig_s[idx] & ~URGENT[idx]);
        end
        any_s = urg_any_s | rr_any_s;
        sel_s = urg_any_s ? urg_sel_s : rr_sel_s;
        for (int i = 0; i < NCH; i++) begin
            sel_cmd_s  = (sel_s == CW'(i)) ? req_cmd[2*i +: 2]    : sel_cmd_s;
            sel_addr_s = (sel_s == CW'(i)) ? req_addr[AW*i +: AW] : sel_addr_s;
        end
    end

    // Data-phase strobe routing and error/watchdog qualifiers
    always_comb begin
        is_rd_s      = cmd_q[1];
        in_data_s    = (state_q == DATA);
        rd_hit_s     = in_data_s & is_rd_s & sys_rd_data_valid;
        wr_hit_s     = in_data_s & ~is_rd_s & sys_wr_data_valid;
        beat_s       = rd_hit_s | wr_hit_s;
        last_beat_s  = beat_s & (beats_q == BW'(1));
        bad_strobe_s = in_data_s ? (is_rd_s ? sys_wr_data_valid : sys_rd_data_valid)
                                 : (sys_rd_data_valid | sys_wr_data_valid);
        wd_exp_s     = (wd_q == WW'(TIMEOUT - 1));
        owner_oh_s   = ONE << owner_q;
        rd_valid     = rd_hit_s ? owner_oh_s : {NCH{1'b0}};
        wr_valid     = wr_hit_s ? owner_oh_s : {NCH{1'b0}};
    end

    // Arbitration FSM with registered controller-side outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            ch_q       <= {CW{1'b0}};
            rr_q       <= CW'(NCH - 1);
            owner_q    <= {CW{1'b0}};
            cmd_q      <= 2'b00;
            sys_cmd_q  <= 2'b00;
            sys_addr_q <= {AW{1'b0}};
            gnt_q      <= {NCH{1'b0}};
            beats_q    <= {BW{1'b0}};
            wd_q       <= {WW{1'b0}};
            busy_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            gnt_q <= {NCH{1'b0}};
            err_q <= err_q | bad_strobe_s;
            case (state_q)
                IDLE: begin
                    wd_q <= {WW{1'b0}};
                    if (any_s) begin
                        state_q    <= ISSUE;
                        ch_q       <= sel_s;
                        cmd_q      <= sel_cmd_s;
                        sys_cmd_q  <= sel_cmd_s;
                        sys_addr_q <= sel_addr_s;
                        busy_q     <= 1'b1;
                    end else begin
                        sys_cmd_q <= 2'b00;
                        busy_q    <= 1'b0;
                    end
                end
                ISSUE: begin
                    if (sys_cmd_ack != 2'b00) begin
                        state_q   <= DATA;
                        gnt_q     <= ONE << ch_q;
                        owner_q   <= ch_q;
                        beats_q   <= (cmd_q == 2'b10) ? BW'(BEATS_SHORT) : BW'(BEATS_LONG);
                        rr_q      <= URGENT[ch_q] ? rr_q : ch_q;
                        sys_cmd_q <= 2'b00;
                        wd_q      <= {WW{1'b0}};
                    end else if (wd_exp_s) begin
                        state_q   <= IDLE;
                        err_q     <= 1'b1;
                        sys_cmd_q <= 2'b00;
                        busy_q    <= 1'b0;
                        wd_q      <= {WW{1'b0}};
                    end else begin
                        wd_q <= wd_q + WW'(1);
                    end
                end
                DATA: begin
                    if (last_beat_s) begin
                        state_q <= IDLE;
                        beats_q <= beats_q - BW'(1);
                        busy_q  <= 1'b0;
                        wd_q    <= {WW{1'b0}};
                    end else if (wd_exp_s) begin
                        state_q <= IDLE;
                        err_q   <= 1'b1;
                        busy_q  <= 1'b0;
                        wd_q    <= {WW{1'b0}};
                    end else begin
                        wd_q    <= wd_q + WW'(1);
                        beats_q <= beat_s ? (beats_q - BW'(1)) : beats_q;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    sys_cmd_q <= 2'b00;
                    busy_q    <= 1'b0;
                    wd_q      <= {WW{1'b0}};
                end
            endcase
        end
    end

    assign gnt      = gnt_q;
    assign sys_CMD  = sys_cmd_q;
    assign sys_ADDR = sys_addr_q;
    assign owner    = owner_q;
    assign busy     = busy_q;
    assign err      = err_q;

endmodule

// File: tb/tb_sdram_req_arbiter.sv
// Scoreboard bench for sdram_req_arbiter: expected grants are queued by the stimulus
// and checked by an independent monitor; strobe routing is counted per channel.
module tb_sdram_req_arbiter;

    localparam int NCH = 4;
    localparam int AW  = 23;

    typedef struct packed {
        logic [1:0]    ch;
        logic [1:0]    cmd;
        logic [AW-1:0] addr;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    req;
    logic [2*NCH-1:0]  req_cmd;
    logic [AW*NCH-1:0] req_addr;
    logic [NCH-1:0]    gnt;
    logic [1:0]        sys_CMD;
    logic [AW-1:0]     sys_ADDR;
    logic [1:0]        sys_cmd_ack;
    logic              sys_rd_data_valid;
    logic              sys_wr_data_valid;
    logic [NCH-1:0]    rd_valid;
    logic [NCH-1:0]    wr_valid;
    logic [1:0]        owner;
    logic              busy;
    logic              err;

    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   rd_cnt[NCH] = '{default: 0};
    int   wr_cnt[NCH] = '{default: 0};
    int   cmd_cycles = 0;
    logic [1:0]    last_cmd = 2'b00;
    logic [AW-1:0] last_addr = '0;

    sdram_req_arbiter dut (
        .clk(clk), .rst(rst), .req(req), .req_cmd(req_cmd), .req_addr(req_addr),
        .gnt(gnt), .sys_CMD(sys_CMD), .sys_ADDR(sys_ADDR), .sys_cmd_ack(sys_cmd_ack),
        .sys_rd_data_valid(sys_rd_data_valid), .sys_wr_data_valid(sys_wr_data_valid),
        .rd_valid(rd_valid), .wr_valid(wr_valid), .owner(owner), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [1:0] c, input logic [AW-1:0] a);
        req_cmd[2*ch +: 2]   = c;
        req_addr[AW*ch +: AW] = a;
    endtask

    task automatic push(input int ch, input logic [1:0] c, input logic [AW-1:0] a);
        exp_t e;
        e.ch   = 2'(ch);
        e.cmd  = c;
        e.addr = a;
        exp_q.push_back(e);
    endtask

    // Acts as the controller: waits for a command, acks it, then streams all beats.
    task automatic serve(input int ack_dly, input bit drop, input logic [NCH-1:0] raise);
        logic [1:0] c;
        int n;
        int t;
        t = 0;
        while (sys_CMD == 2'b00 && t < 50) begin
            step();
            t++;
        end
        check("cmd_issued", (t < 50), 1);
        c = sys_CMD;
        req = req | raise;
        for (int i = 1; i < ack_dly; i++) step();
        sys_cmd_ack = 2'b01;
        step();
        sys_cmd_ack = 2'b00;
        if (drop) req = req & ~gnt;
        n = (c == 2'b10) ? 16 : 128;
        for (int i = 0; i < n; i++) begin
            if (c == 2'b01) sys_wr_data_valid = 1'b1;
            else sys_rd_data_valid = 1'b1;
            step();
        end
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
    endtask

    // Monitor: tracks issued command, counts routed strobes, scores each grant
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sys_CMD != 2'b00) begin
                last_cmd  = sys_CMD;
                last_addr = sys_ADDR;
                cmd_cycles++;
            end
            for (int i = 0; i < NCH; i++) begin
                rd_cnt[i] += int'(rd_valid[i]);
                wr_cnt[i] += int'(wr_valid[i]);
            end
            if (gnt != 4'b0000) begin
                if (exp_q.size() == 0) begin
                    check("gnt_unexpected", gnt, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("gnt_onehot", gnt, 4'b0001 << e.ch);
                    check("gnt_cmd", last_cmd, e.cmd);
                    check("gnt_addr", last_addr, e.addr);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got running, want finished");
        $fatal(1, "bench time limit expired");
    end

    initial begin
        int b0;
        int b1;
        rst = 1'b1;
        req = '0;
        req_cmd = '0;
        req_addr = '0;
        sys_cmd_ack = 2'b00;
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b0;
        repeat (3) step();
        check("rst_sys_CMD", sys_CMD, 0);
        check("rst_sys_ADDR", sys_ADDR, 0);
        check("rst_gnt", gnt, 0);
        check("rst_owner", owner, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        rst = 1'b0;
        step();

        // Round-robin fairness: 1,2,3,1,2,3 with ch3 doing 256-byte writes
        set_ch(1, 2'b10, 23'h000011);
        set_ch(2, 2'b10, 23'h000022);
        set_ch(3, 2'b01, 23'h000033);
        for (int r = 0; r < 2; r++) begin
            push(1, 2'b10, 23'h000011);
            push(2, 2'b10, 23'h000022);
            push(3, 2'b01, 23'h000033);
        end
        b0 = wr_cnt[3];
        req = 4'b1110;
        for (int r = 0; r < 6; r++) serve(1, 1'b0, 4'b0000);
        req = 4'b0000;
        check("rr_wr_beats_ch3", wr_cnt[3] - b0, 256);

        // Single 32-byte read, ack in the third command cycle
        set_ch(1, 2'b10, 23'h400008);
        push(1, 2'b10, 23'h400008);
        b0 = cmd_cycles;
        b1 = rd_cnt[1];
        req = 4'b0010;
        serve(3, 1'b1, 4'b0000);
        check("single_cmd_cycles", cmd_cycles - b0, 3);
        check("single_rd_beats", rd_cnt[1] - b1, 16);
        check("single_busy_end", busy, 0);

        // Urgent ch0 against round-robin ch2/ch3
        set_ch(0, 2'b10, 23'h000100);
        set_ch(2, 2'b10, 23'h000200);
        set_ch(3, 2'b10, 23'h000300);
        push(0, 2'b10, 23'h000100);
        push(2, 2'b10, 23'h000200);
        push(0, 2'b10, 23'h000100);
        push(3, 2'b10, 23'h000300);
        push(2, 2'b10, 23'h000200);
        req = 4'b0101;
        serve(1, 1'b1, 4'b0000);
        serve(1, 1'b1, 4'b1001);
        serve(1, 1'b1, 4'b0100);
        serve(1, 1'b1, 4'b0000);
        serve(1, 1'b1, 4'b0000);
        check("urgent_req_drained", req, 0);

        // Withdrawn request: ch2 drops req right after selection
        set_ch(2, 2'b11, 23'h0ABCDE);
        push(2, 2'b11, 23'h0ABCDE);
        b0 = rd_cnt[2];
        req = 4'b0100;
        step();
        req = 4'b0000;
        serve(1, 1'b0, 4'b0000);
        check("withdrawn_rd_beats", rd_cnt[2] - b0, 128);
        check("err_clean_so_far", err, 0);

        // Wrong-direction strobe during a read burst
        set_ch(1, 2'b10, 23'h000111);
        push(1, 2'b10, 23'h000111);
        b0 = rd_cnt[1];
        b1 = wr_cnt[1];
        req = 4'b0010;
        step();
        req = 4'b0000;
        sys_cmd_ack = 2'b10;
        step();
        sys_cmd_ack = 2'b00;
        for (int i = 0; i < 5; i++) begin
            sys_rd_data_valid = 1'b1;
            step();
        end
        sys_rd_data_valid = 1'b0;
        sys_wr_data_valid = 1'b1;
        #1;
        check("wrongdir_wr_valid", wr_valid, 0);
        check("wrongdir_rd_valid", rd_valid, 0);
        step();
        sys_wr_data_valid = 1'b0;
        check("wrongdir_err", err, 1);
        for (int i = 0; i < 10; i++) begin
            sys_rd_data_valid = 1'b1;
            step();
        end
        check("wrongdir_cnt_held", busy, 1);
        step();
        sys_rd_data_valid = 1'b0;
        check("wrongdir_done", busy, 0);
        check("wrongdir_rd_beats", rd_cnt[1] - b0, 16);
        check("wrongdir_wr_beats", wr_cnt[1] - b1, 0);

        // Reset after beat 40 of a 256-byte read
        set_ch(1, 2'b11, 23'h012345);
        push(1, 2'b11, 23'h012345);
        b0 = rd_cnt[1];
        req = 4'b0010;
        step();
        req = 4'b0000;
        sys_cmd_ack = 2'b01;
        step();
        sys_cmd_ack = 2'b00;
        for (int i = 0; i < 40; i++) begin
            sys_rd_data_valid = 1'b1;
            step();
        end
        check("midburst_rd_beats", rd_cnt[1] - b0, 40);
        check("midburst_owner", owner, 1);
        rst = 1'b1;
        #1;
        check("rstmid_rd_valid", rd_valid, 0);
        check("rstmid_busy", busy, 0);
        check("rstmid_owner", owner, 0);
        check("rstmid_err", err, 0);
        check("rstmid_sys_CMD", sys_CMD, 0);
        check("rstmid_sys_ADDR", sys_ADDR, 0);
        sys_rd_data_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
        set_ch(0, 2'b10, 23'h000050);
        set_ch(1, 2'b10, 23'h000051);
        set_ch(2, 2'b10, 23'h000052);
        push(0, 2'b10, 23'h000050);
        push(1, 2'b10, 23'h000051);
        push(2, 2'b10, 23'h000052);
        req = 4'b0111;
        serve(1, 1'b1, 4'b0000);
        serve(1, 1'b1, 4'b0000);
        serve(1, 1'b1, 4'b0000);
        check("post_rst_err", err, 0);

        // Withheld ack: watchdog fires after 1023 cycles in ISSUE, no grant
        set_ch(3, 2'b01, 23'h7ABCDE);
        req = 4'b1000;
        step();
        req = 4'b0000;
        for (int i = 0; i < 1022; i++) step();
        check("wd_still_issue", busy, 1);
        check("wd_cmd_held", sys_CMD, 2'b01);
        step();
        check("wd_busy", busy, 0);
        check("wd_err", err, 1);
        check("wd_sys_CMD", sys_CMD, 0);
        repeat (5) step();
        check("scoreboard_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
